random_delay_timer: RTL and testbench
=====================================

# random_delay_timer

Consumes the free-running 28-bit LFSR word and turns it into a random wait followed by a timed response window, for the reaction-time trial path. On `start` it samples the LFSR, waits a pseudo-random number of cycles, raises `go`, then counts prescaled ticks until `stop`. It reports the elapsed count, a false-start flag or a timeout flag. It sits directly downstream of the LFSR and upstream of the display/score logic.

## Interface
- `MIN_DELAY`, default 50_000_000: fixed floor of the wait, in clk cycles.
- `RANGE_BITS`, default 26: number of low LFSR bits added to the wait (1..28).
- `TICK_DIV`, default 50_000: clk cycles per reaction tick (≥1).
- `COUNT_W`, default 16: width of `reaction_count`.
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `lfsr_in` in 28: LFSR word, same clock domain, sampled only on accepted `start`.
- `start` in 1: begin a trial. Accepted only in IDLE.
- `stop` in 1: response button, synchronised/debounced upstream. Level-sensitive.
- `busy` out 1: high in WAIT and GO.
- `go` out 1: high exactly while in GO.
- `done` out 1: one-cycle pulse when a trial ends, for any reason.
- `early` out 1: false start. Held until next accepted `start`.
- `timeout` out 1: count saturated. Held until next accepted `start`.
- `reaction_count` out COUNT_W: ticks elapsed in GO. Held until next accepted `start`.

## Operation
- Wait length is D = MIN_DELAY + lfsr_in[RANGE_BITS-1:0]. Computed at width max(bits(MIN_DELAY), RANGE_BITS)+1, so there is no overflow.
- FSM has three states: IDLE, WAIT, GO.
- **IDLE + start:** load `delay_cnt`=D. Clear `early`, `timeout`, `reaction_count` and the prescaler. Next state WAIT.
- **IDLE, other inputs:** `stop` is ignored.
- **WAIT + stop:** set `early`=1, pulse `done`, go to IDLE. `reaction_count` stays 0. This has priority over expiry.
- **WAIT, delay_cnt==0, no stop:** go to GO and clear the prescaler.
- **WAIT, otherwise:** decrement `delay_cnt`.
- **GO + stop:** pulse `done`, go to IDLE. `reaction_count` freezes at its current value; there is no increment in that cycle.
- **GO, otherwise:** the prescaler counts 0..TICK_DIV-1. On wrap, `reaction_count` increments.
- **Saturation:** when `reaction_count` would exceed all-ones, hold it at all-ones, set `timeout`=1, pulse `done`, go to IDLE.
- `start` is ignored while `busy` (no restart, no resample).
- `go` and `busy` are decoded from the state register, so they have no glitch path from inputs.
- Any `lfsr_in` value is legal, including 0 and all-ones (the LFSR's locked-up state).

## Timing
- **Reset values:** state=IDLE. `busy`, `go`, `done`, `early`, `timeout` = 0. `reaction_count`=0. `delay_cnt`=0. Prescaler=0.
- **Reset mid-trial:** the same values on the next edge. Any trial in progress is abandoned and no `done` pulse is issued.
- **Wait latency:** `start` seen at edge 0. WAIT occupies edges 1..D+1 (delay_cnt D..0). `go` rises after edge D+1 and is first high in cycle D+2.
- **Early-stop boundary:** `stop` in the final WAIT cycle (delay_cnt==0) is early; `go` never rises.
- **Stop on first GO cycle:** gives `reaction_count`=0, no timeout.
- **Tick timing:** first increment occurs TICK_DIV cycles after entering GO.
- **done:** a single-cycle pulse coincident with the return to IDLE. Result registers are valid in the same cycle.
- **Back-to-back trials:** `start` in the cycle after `done` is accepted.

## Structure
- Shared package `reaction_pkg` holds:
  - the state enum (IDLE/WAIT/GO);
  - the LFSR width constant 28;
  - default COUNT_W/TICK_DIV;
  - a function for the delay-counter width.
- One sub-module, `tick_prescaler`:
  - parameter TICK_DIV;
  - inputs `clk`, `reset`, `clear`, `enable`;
  - output `tick`, a one-cycle pulse on wrap.
- FSM, delay counter and result registers stay in the top.

## Test plan
All scenarios run with MIN_DELAY=4, RANGE_BITS=3, TICK_DIV=2, COUNT_W=4.
- **Basic wait:** `lfsr_in`=28'h0000005, start pulse at cycle 0 -> `busy` from cycle 1, `go` first high at cycle 11 (D=9).
- **Normal reaction:** same trial, `stop` at cycle 18 -> `done` pulse with `reaction_count`=3, `early`=0, `timeout`=0, `go` low next cycle.
- **False start:** `lfsr_in`=0, `stop` at cycle 3 (WAIT) -> `early`=1, `done` pulse, `reaction_count`=0. Repeat with `stop` exactly at delay_cnt==0 -> still `early`, `go` never seen.
- **Timeout:** no `stop` -> `reaction_count` reaches 15, `timeout`=1, `done` pulse, back to IDLE. Later `stop` has no effect.
- **Ignored inputs:** `start` during WAIT and GO, and `stop` in IDLE -> no state change, `lfsr_in` not resampled.
- **Reset:** `reset` asserted mid-GO -> next cycle all outputs 0, no `done`. A new `start` with `lfsr_in`=28'hFFFFFFF gives `go` at cycle 13 (D=11).

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time trial path.
// Holds the trial FSM state encoding and the delay-counter width helper.
package reaction_pkg;

  localparam int LFSR_W           = 28;
  localparam int DEFAULT_COUNT_W  = 16;
  localparam int DEFAULT_TICK_DIV = 50_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GO   = 2'd2
  } state_t;

  // One extra bit over the wider addend keeps MIN_DELAY + random part from overflowing.
  function automatic int delay_width(input int min_delay, input int range_bits);
    int floor_bits;
    floor_bits = $clog2(min_delay + 1);
    return ((floor_bits > range_bits) ? floor_bits : range_bits) + 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// clear has priority over enable and returns the phase to zero.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] phase;

  assign tick = enable && !clear && (phase == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase <= '0;
    end else if (enable) begin
      if (phase == LAST) begin
        phase <= '0;
      end else begin
        phase <= phase + PW'(1);
      end
    end
  end

endmodule

// File: rtl/random_delay_timer.sv
// Reaction-time trial: random wait seeded from the LFSR, then a prescaled
// response window that reports elapsed ticks, a false start or a timeout.
module random_delay_timer
  import reaction_pkg::*;
#(
  parameter int MIN_DELAY  = 50_000_000,
  parameter int RANGE_BITS = 26,
  parameter int TICK_DIV   = DEFAULT_TICK_DIV,
  parameter int COUNT_W    = DEFAULT_COUNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LFSR_W-1:0]  lfsr_in,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic               go,
  output logic               done,
  output logic               early,
  output logic               timeout,
  output logic [COUNT_W-1:0] reaction_count
);

  localparam int DW = delay_width(MIN_DELAY, RANGE_BITS);
  localparam logic [DW-1:0] MIN_D = DW'(MIN_DELAY);

  state_t state, next_state;

  logic [DW-1:0] delay_cnt;
  logic [DW-1:0] delay_load;

  logic accept;
  logic dec_delay;
  logic end_early;
  logic end_stop;
  logic end_timeout;
  logic inc_count;
  logic tick;
  logic presc_clear;
  logic presc_enable;

  // Bits of the LFSR word above RANGE_BITS do not contribute to the wait.
  logic [LFSR_W-1:0] unused_lfsr;
  assign unused_lfsr = lfsr_in;

  assign delay_load = MIN_D + {{(DW-RANGE_BITS){1'b0}}, lfsr_in[RANGE_BITS-1:0]};

  assign busy = (state != IDLE);
  assign go   = (state == GO);

  // Prescaler phase is held at zero outside GO, so every GO entry starts a fresh tick period.
  assign presc_clear  = (state != GO);
  assign presc_enable = (state == GO) && !stop;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (presc_clear),
    .enable(presc_enable),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    dec_delay   = 1'b0;
    end_early   = 1'b0;
    end_stop    = 1'b0;
    end_timeout = 1'b0;
    inc_count   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (stop) begin
          end_early  = 1'b1;
          next_state = IDLE;
        end else if (delay_cnt == '0) begin
          next_state = GO;
        end else begin
          dec_delay = 1'b1;
        end
      end
      GO: begin
        if (stop) begin
          end_stop   = 1'b1;
          next_state = IDLE;
        end else if (tick) begin
          if (&reaction_count) begin
            end_timeout = 1'b1;
            next_state  = IDLE;
          end else begin
            inc_count = 1'b1;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Results are cleared only by an accepted start so they stay readable after done.
  always_ff @(posedge clk) begin
    if (reset) begin
      delay_cnt      <= '0;
      done           <= 1'b0;
      early          <= 1'b0;
      timeout        <= 1'b0;
      reaction_count <= '0;
    end else begin
      done <= end_early || end_stop || end_timeout;
      if (accept) begin
        delay_cnt      <= delay_load;
        early          <= 1'b0;
        timeout        <= 1'b0;
        reaction_count <= '0;
      end else begin
        if (dec_delay) begin
          delay_cnt <= delay_cnt - DW'(1);
        end
        if (end_early) begin
          early <= 1'b1;
        end
        if (end_timeout) begin
          timeout <= 1'b1;
        end
        if (inc_count) begin
          reaction_count <= reaction_count + COUNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_random_delay_timer.sv
// Directed bench for random_delay_timer with small parameters so every
// trial's cycle-by-cycle timing can be worked out by hand.
module tb_random_delay_timer;

  localparam int MIN_DELAY  = 4;
  localparam int RANGE_BITS = 3;
  localparam int TICK_DIV   = 2;
  localparam int COUNT_W    = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [27:0]        lfsr_in;
  logic               start;
  logic               stop;
  logic               busy;
  logic               go;
  logic               done;
  logic               early;
  logic               timeout;
  logic [COUNT_W-1:0] reaction_count;

  int tests_run    = 0;
  int tests_failed = 0;

  random_delay_timer #(
    .MIN_DELAY (MIN_DELAY),
    .RANGE_BITS(RANGE_BITS),
    .TICK_DIV  (TICK_DIV),
    .COUNT_W   (COUNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .lfsr_in       (lfsr_in),
    .start         (start),
    .stop          (stop),
    .busy          (busy),
    .go            (go),
    .done          (done),
    .early         (early),
    .timeout       (timeout),
    .reaction_count(reaction_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s_start, input logic s_stop, input logic [27:0] s_lfsr);
    start   = s_start;
    stop    = s_stop;
    lfsr_in = s_lfsr;
  endtask

  // Advance n rising edges and land just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 28'h0);
    step(2);
    reset = 1'b0;
    step(1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_go", go, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_early", early, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_count", reaction_count, 0);

    // Basic wait and normal reaction, D = 4 + 5 = 9, with ignored starts in WAIT and GO.
    applyStimulus(1'b1, 1'b0, 28'h0000005);
    step(1);
    applyStimulus(1'b0, 1'b0, 28'h0000005);
    checkOutput("basic_busy_c1", busy, 1);
    checkOutput("basic_go_c1", go, 0);
    step(3);
    applyStimulus(1'b1, 1'b0, 28'h0000000);
    step(1);
    applyStimulus(1'b0, 1'b0, 28'h0000005);
    step(5);
    checkOutput("basic_go_c10", go, 0);
    checkOutput("basic_busy_c10", busy, 1);
    step(1);
    checkOutput("basic_go_c11", go, 1);
    step(2);
    checkOutput("basic_count_c13", reaction_count, 1);
    applyStimulus(1'b1, 1'b0, 28'h0000000);
    step(1);
    applyStimulus(1'b0, 1'b0, 28'h0000005);
    checkOutput("ign_start_go_c14", go, 1);
    step(4);
    checkOutput("basic_go_c18", go, 1);
    checkOutput("basic_count_c18", reaction_count, 3);
    applyStimulus(1'b0, 1'b1, 28'h0000005);
    step(1);
    checkOutput("react_done", done, 1);
    checkOutput("react_count", reaction_count, 3);
    checkOutput("react_early", early, 0);
    checkOutput("react_timeout", timeout, 0);
    checkOutput("react_go_low", go, 0);
    checkOutput("react_busy_low", busy, 0);
    applyStimulus(1'b0, 1'b0, 28'h0000005);
    step(1);
    checkOutput("react_done_pulse", done, 0);
    checkOutput("react_count_held", reaction_count, 3);
    applyStimulus(1'b0, 1'b1, 28'h0000005);
    step(2);
    checkOutput("idle_stop_busy", busy, 0);
    checkOutput("idle_stop_done", done, 0);
    checkOutput("idle_stop_count", reaction_count, 3);

    // False start mid-WAIT, D = 4.
    applyStimulus(1'b1, 1'b0, 28'h0000000);
    step(1);
    applyStimulus(1'b0, 1'b0, 28'h0000000);
    step(2);
    applyStimulus(1'b0, 1'b1, 28'h0000000);
    step(1);
    checkOutput("early_done", done, 1);
    checkOutput("early_flag", early, 1);
    checkOutput("early_count", reaction_count, 0);
    checkOutput("early_busy", busy, 0);
    applyStimulus(1'b0, 1'b0, 28'h0000000);
    step(1);
    checkOutput("early_done_pulse", done, 0);
    checkOutput("early_held", early, 1);

    // Back-to-back start, stop exactly at delay_cnt == 0.
    applyStimulus(1'b1, 1'b0, 28'h0000000);
    step(1);
    applyStimulus(1'b0, 1'b0, 28'h0000000);
    checkOutput("b2b_busy", busy, 1);
    checkOutput("b2b_early_clr", early, 0);
    step(4);
    checkOutput("edge_go_c5", go, 0);
    applyStimulus(1'b0, 1'b1, 28'h0000000);
    step(1);
    checkOutput("edge_early", early, 1);
    checkOutput("edge_done", done, 1);
    checkOutput("edge_go_c6", go, 0);
    applyStimulus(1'b0, 1'b0, 28'h0000000);
    step(1);
    checkOutput("edge_go_c7", go, 0);
    checkOutput("edge_busy_c7", busy, 0);

    // Timeout: count n visible at cycle 6 + 2n, saturating tick at cycle 37.
    applyStimulus(1'b1, 1'b0, 28'h0000000);
    step(1);
    applyStimulus(1'b0, 1'b0, 28'h0000000);
    checkOutput("to_early_clr", early, 0);
    step(5);
    checkOutput("to_go_c6", go, 1);
    step(31);
    checkOutput("to_count_c37", reaction_count, 15);
    checkOutput("to_flag_c37", timeout, 0);
    checkOutput("to_go_c37", go, 1);
    step(1);
    checkOutput("to_done", done, 1);
    checkOutput("to_flag", timeout, 1);
    checkOutput("to_count", reaction_count, 15);
    checkOutput("to_busy", busy, 0);
    applyStimulus(1'b0, 1'b1, 28'h0000000);
    step(2);
    checkOutput("to_late_stop_flag", timeout, 1);
    checkOutput("to_late_stop_count", reaction_count, 15);
    checkOutput("to_late_stop_done", done, 0);
    checkOutput("to_late_stop_early", early, 0);

    // Reset mid-GO, then a locked-up LFSR word giving D = 11.
    applyStimulus(1'b1, 1'b0, 28'h0000005);
    step(1);
    applyStimulus(1'b0, 1'b0, 28'h0000005);
    checkOutput("rg_timeout_clr", timeout, 0);
    step(14);
    checkOutput("rg_go_c15", go, 1);
    checkOutput("rg_count_c15", reaction_count, 2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checkOutput("rg_busy", busy, 0);
    checkOutput("rg_go", go, 0);
    checkOutput("rg_done", done, 0);
    checkOutput("rg_early", early, 0);
    checkOutput("rg_timeout", timeout, 0);
    checkOutput("rg_count", reaction_count, 0);
    applyStimulus(1'b1, 1'b0, 28'hFFFFFFF);
    step(1);
    applyStimulus(1'b0, 1'b0, 28'hFFFFFFF);
    step(11);
    checkOutput("ones_go_c12", go, 0);
    checkOutput("ones_busy_c12", busy, 1);
    step(1);
    checkOutput("ones_go_c13", go, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
